// File: rtl/tank_pkg.sv
// Shared types, display-mux modes and per-channel limits for the tank monitor.
// Channels: 0 cleanliness, 1 temperature, 2 food storage, 3 saltiness.
package tank_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_FISH,
        SAMPLE,
        LOAD,
        SHOW_CH,
        ERROR
    } state_t;

    localparam logic [4:0] MUX_OFF   = 5'b00000;
    localparam logic [4:0] MUX_FISH  = 5'b00001;
    localparam logic [4:0] MUX_CLEAN = 5'b00010;
    localparam logic [4:0] MUX_TEMP  = 5'b00100;
    localparam logic [4:0] MUX_FOOD  = 5'b01000;
    localparam logic [4:0] MUX_SALT  = 5'b10000;
    localparam logic [4:0] MUX_ERR   = 5'b11111;

    localparam logic [3:0][7:0] LIM_LO = {8'h20, 8'h10, 8'h14, 8'h08};
    localparam logic [3:0][7:0] LIM_HI = {8'h60, 8'hFF, 8'h1E, 8'hFF};

    function automatic logic [4:0] ch_mode(input logic [1:0] ch);
        logic [4:0] m;
        unique case (ch)
            2'd0:    m = MUX_CLEAN;
            2'd1:    m = MUX_TEMP;
            2'd2:    m = MUX_FOOD;
            default: m = MUX_SALT;
        endcase
        return m;
    endfunction

    // Limits are inclusive: only values strictly outside flag an alarm.
    function automatic logic out_of_range(
        input logic [1:0] ch,
        input logic [7:0] v
    );
        return (v < LIM_LO[ch]) || (v > LIM_HI[ch]);
    endfunction

endpackage

// File: rtl/tank_dwell_timer.sv
// Loadable 8-bit down-counter; saturates at zero, done on the last counted cycle.
module tank_dwell_timer (
    input  logic       CLK,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count <= 8'd1);

endmodule

// File: rtl/tank_monitor_sequencer.sv
// Scan sequencer: samples four tank sensors, loads registers, drives the display mux.
// Build option: define TANK_ALARM_STICKY_EN to keep alarm_ch bits set across scans.
module tank_monitor_sequencer
    import tank_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic       alarm_clr,
    input  logic       sample_valid,
    input  logic [7:0] sample_data,
    output logic       sample_req,
    output logic [1:0] ch_sel,
    output logic [3:0] ld_en,
    output logic [7:0] ld_data,
    output logic [4:0] mux_select,
    output logic       busy,
    output logic [3:0] alarm_ch,
    output logic       alarm
);

    localparam logic [7:0] DWELL_LD   = 8'(DWELL_CYCLES);
    localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT_CYCLES);

    state_t     state, state_nxt;
    logic [1:0] ch_nxt;
    logic [7:0] cap;
    logic [3:0] alarm_nxt;
    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       tmr_done;

    tank_dwell_timer u_timer (
        .CLK      (CLK),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ch_nxt     = ch_sel;
        tmr_load   = 1'b0;
        tmr_val    = DWELL_LD;
        sample_req = 1'b0;
        ld_en      = 4'b0000;
        mux_select = MUX_OFF;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = SHOW_FISH;
                    ch_nxt    = 2'd0;
                    tmr_load  = 1'b1;
                end
            end
            SHOW_FISH: begin
                mux_select = MUX_FISH;
                if (tmr_done) begin
                    state_nxt = SAMPLE;
                    tmr_load  = 1'b1;
                    tmr_val   = TIMEOUT_LD;
                end
            end
            SAMPLE: begin
                sample_req = 1'b1;
                // A valid arriving on the timeout cycle still counts.
                if (sample_valid)  state_nxt = LOAD;
                else if (tmr_done) state_nxt = ERROR;
            end
            LOAD: begin
                ld_en     = 4'b0001 << ch_sel;
                state_nxt = SHOW_CH;
                tmr_load  = 1'b1;
            end
            SHOW_CH: begin
                mux_select = ch_mode(ch_sel);
                if (tmr_done) begin
                    if (ch_sel == 2'd3) begin
                        state_nxt = IDLE;
                        ch_nxt    = 2'd0;
                    end else begin
                        state_nxt = SAMPLE;
                        ch_nxt    = ch_sel + 2'd1;
                        tmr_load  = 1'b1;
                        tmr_val   = TIMEOUT_LD;
                    end
                end
            end
            ERROR: begin
                busy       = 1'b0;
                mux_select = MUX_ERR;
                if (alarm_clr) begin
                    state_nxt = IDLE;
                    ch_nxt    = 2'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear first, then let this cycle's range check set its bit.
    always_comb begin
        alarm_nxt = alarm_clr ? 4'b0000 : alarm_ch;
        if (state == LOAD) begin
`ifdef TANK_ALARM_STICKY_EN
            alarm_nxt[ch_sel] = alarm_nxt[ch_sel] | out_of_range(ch_sel, cap);
`else
            alarm_nxt[ch_sel] = out_of_range(ch_sel, cap);
`endif
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ch_sel   <= 2'd0;
            cap      <= 8'd0;
            alarm_ch <= 4'b0000;
        end else begin
            ch_sel   <= ch_nxt;
            alarm_ch <= alarm_nxt;
            if (state == SAMPLE && sample_valid) cap <= sample_data;
        end
    end

    assign ld_data = (state == LOAD) ? cap : 8'd0;
    assign alarm   = (|alarm_ch) || (state == ERROR);

endmodule

// File: tb/tb_tank_monitor_sequencer.sv
// Self-checking bench for tank_monitor_sequencer: scan vectors, timeout, reset.
// Honours TANK_ALARM_STICKY_EN when computing expected alarm flags.
module tb_tank_monitor_sequencer;

    localparam int DWELL = 4;
    localparam int TMO   = 8;

    logic       CLK = 1'b0;
    logic       reset;
    logic       start;
    logic       alarm_clr;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       sample_req;
    logic [1:0] ch_sel;
    logic [3:0] ld_en;
    logic [7:0] ld_data;
    logic [4:0] mux_select;
    logic       busy;
    logic [3:0] alarm_ch;
    logic       alarm;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    tank_monitor_sequencer #(
        .DWELL_CYCLES   (DWELL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .alarm_clr    (alarm_clr),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_req   (sample_req),
        .ch_sel       (ch_sel),
        .ld_en        (ld_en),
        .ld_data      (ld_data),
        .mux_select   (mux_select),
        .busy         (busy),
        .alarm_ch     (alarm_ch),
        .alarm        (alarm)
    );

    // Sensor model: answers on the vdelay-th request cycle for enabled channels.
    logic [3:0][7:0] sdat;
    logic [3:0]      vmask;
    int              vdelay;
    int              req_cnt;

    always @(posedge CLK or posedge reset) begin
        if (reset) req_cnt <= 0;
        else       req_cnt <= sample_req ? req_cnt + 1 : 0;
    end

    always_comb begin
        sample_valid = sample_req && vmask[ch_sel] && (req_cnt >= vdelay - 1);
        sample_data  = sdat[ch_sel];
    end

    typedef struct packed {
        logic       busy;
        logic       req;
        logic [4:0] mux;
        logic [3:0] ld;
        logic [7:0] dat;
        logic [1:0] ch;
    } obs_t;

    typedef struct {
        logic [3:0][7:0] s;
        logic [3:0]      exp_alarm;
    } vec_t;

    obs_t q[$];
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic obs_t mk(input logic b, input logic r,
                                input logic [4:0] m, input logic [3:0] l,
                                input logic [7:0] d, input logic [1:0] c);
        obs_t o;
        o.busy = b;
        o.req  = r;
        o.mux  = m;
        o.ld   = l;
        o.dat  = d;
        o.ch   = c;
        return o;
    endfunction

    function automatic obs_t observe(input bit keep_dat);
        return mk(busy, sample_req, mux_select, ld_en,
                  keep_dat ? ld_data : 8'h00, ch_sel);
    endfunction

    task automatic run_scan(input logic [3:0][7:0] s, input bit hold);
        logic [4:0] modes [4];
        obs_t       e;
        int         n;
        modes = '{5'b00010, 5'b00100, 5'b01000, 5'b10000};
        sdat  = s;
        @(negedge CLK);
        start = 1'b1;
        for (int i = 0; i < DWELL; i++)
            q.push_back(mk(1'b1, 1'b0, 5'b00001, 4'b0, 8'h00, 2'd0));
        for (int c = 0; c < 4; c++) begin
            q.push_back(mk(1'b1, 1'b1, 5'b00000, 4'b0, 8'h00, 2'(c)));
            q.push_back(mk(1'b1, 1'b0, 5'b00000, 4'(1 << c), s[c], 2'(c)));
            for (int i = 0; i < DWELL; i++)
                q.push_back(mk(1'b1, 1'b0, modes[c], 4'b0, 8'h00, 2'(c)));
        end
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (!hold) start = 1'b0;
            e = q.pop_front();
            chk($sformatf("seq[%0d]", i), 32'(observe(e.ld != 4'b0)), 32'(e));
        end
        start = 1'b0;
        @(negedge CLK);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ch", 32'(ch_sel), 32'd0);
        chk("end_mux", 32'(mux_select), 32'd0);
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        alarm_clr = 1'b1;
        @(negedge CLK);
        alarm_clr = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ch"},   32'(ch_sel), 32'd0);
        chk({tag, "_ld"},   32'(ld_en), 32'd0);
        chk({tag, "_dat"},  32'(ld_data), 32'd0);
        chk({tag, "_req"},  32'(sample_req), 32'd0);
        chk({tag, "_mux"},  32'(mux_select), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ach"},  32'(alarm_ch), 32'd0);
        chk({tag, "_alm"},  32'(alarm), 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] acc;
        bit         sticky;
        int         n;
        int         cnt;

`ifdef TANK_ALARM_STICKY_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        vecs[0] = '{s: {8'h70, 8'h38, 8'h1C, 8'h0E}, exp_alarm: 4'b1000};
        vecs[1] = '{s: {8'h40, 8'h10, 8'h14, 8'h08}, exp_alarm: 4'b0000};
        vecs[2] = '{s: {8'h20, 8'h0F, 8'h1E, 8'h07}, exp_alarm: 4'b0101};
        vecs[3] = '{s: {8'h60, 8'hFF, 8'h13, 8'hFF}, exp_alarm: 4'b0010};
        vecs[4] = '{s: {8'h61, 8'h00, 8'h1F, 8'h00}, exp_alarm: 4'b1111};

        start     = 1'b0;
        alarm_clr = 1'b0;
        vmask     = 4'b1111;
        vdelay    = 1;
        sdat      = '0;
        reset     = 1'b1;
        @(negedge CLK);
        chk_reset_outputs("rst");
        @(negedge CLK);
        reset = 1'b0;

        acc = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            run_scan(vecs[i].s, i == 2);
            acc = sticky ? (acc | vecs[i].exp_alarm) : vecs[i].exp_alarm;
            chk($sformatf("alarm_ch[%0d]", i), 32'(alarm_ch), 32'(acc));
            chk($sformatf("alarm[%0d]", i), 32'(alarm), 32'(|acc));
            if (i == 1) begin
                pulse_clr();
                acc = 4'b0000;
                chk("idle_clr", 32'(alarm_ch), 32'd0);
            end
        end

        // Channel 1 never answers: timeout into ERROR.
        apply_reset();
        vmask = 4'b1101;
        sdat  = {8'h40, 8'h20, 8'h18, 8'h00};
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        n = 0;
        while (!(sample_req && ch_sel == 2'd1) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("to_reach", 32'(n < 100), 32'd1);
        cnt = 0;
        while (sample_req && cnt < 50) begin
            cnt++;
            @(negedge CLK);
        end
        chk("to_cycles", 32'(cnt), 32'(TMO));
        chk("err_mux", 32'(mux_select), 32'h1F);
        chk("err_alarm", 32'(alarm), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_req", 32'(sample_req), 32'd0);
        chk("err_ld", 32'(ld_en), 32'd0);
        chk("err_ach", 32'(alarm_ch), 32'd1);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        chk("err_start_ign", 32'(mux_select), 32'h1F);
        pulse_clr();
        chk("clr_mux", 32'(mux_select), 32'd0);
        chk("clr_alarm", 32'(alarm), 32'd0);
        chk("clr_ach", 32'(alarm_ch), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        vmask = 4'b1111;

        // Valid arriving on the last allowed SAMPLE cycle.
        vdelay = TMO;
        sdat   = {8'h40, 8'h20, 8'h18, 8'h20};
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        n = 0;
        while (!sample_req && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("late_reach", 32'(n < 50), 32'd1);
        cnt = 0;
        while (sample_req && cnt < 50) begin
            cnt++;
            @(negedge CLK);
        end
        chk("late_cycles", 32'(cnt), 32'(TMO));
        chk("late_ld", 32'(ld_en), 32'b0001);
        chk("late_dat", 32'(ld_data), 32'h20);
        n = 0;
        while (busy && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("late_done", 32'(n < 200), 32'd1);
        chk("late_mux", 32'(mux_select), 32'd0);
        chk("late_alarm", 32'(alarm), 32'd0);
        vdelay = 1;

        // Asynchronous reset during SHOW_CH of channel 2.
        sdat = {8'h40, 8'h20, 8'h18, 8'h00};
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        n = 0;
        while (mux_select != 5'b01000 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("mid_reach", 32'(n < 100), 32'd1);
        chk("mid_ach", 32'(alarm_ch), 32'b0001);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("async");
        @(negedge CLK);
        reset = 1'b0;
        run_scan(vecs[0].s, 1'b0);
        chk("post_rst_ach", 32'(alarm_ch), 32'b1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tank_monitor_sequencer.md
TANK_MONITOR_SEQUENCER -- requirements
Module: tank_monitor_sequencer

Interface
REQ-001 Parameter DWELL_CYCLES, default 4: cycles each display mode is held; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 8: SAMPLE cycles allowed before a timeout; legal range 1..255.
REQ-003 Port CLK  in  1  system clock; all state SHALL change on the rising edge only.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port start  in  1  begin one scan; sampled in IDLE only.
REQ-006 Port alarm_clr  in  1  clear alarms and leave ERROR.
REQ-007 Port sample_valid  in  1  sensor data valid.
REQ-008 Port sample_data  in  8  sensor value for channel ch_sel.
REQ-009 Port sample_req  out  1  request a sample for channel ch_sel.
REQ-010 Port ch_sel  out  2  channel index: 0 cleanliness, 1 temperature, 2 food storage, 3 saltiness.
REQ-011 Port ld_en  out  4  one-hot load enable to the four tank registers, bit = channel.
REQ-012 Port ld_data  out  8  captured sample, valid while ld_en is nonzero.
REQ-013 Port mux_select  out  5  display-mux mode.
REQ-014 Port busy  out  1  high in every state except IDLE and ERROR.
REQ-015 Port alarm_ch  out  4  per-channel out-of-range flags.
REQ-016 Port alarm  out  1  equals OR of alarm_ch, or high in ERROR.

Function
REQ-017 FSM states SHALL be IDLE, SHOW_FISH, SAMPLE, LOAD, SHOW_CH and ERROR.
REQ-018 IDLE: when start=1, go to SHOW_FISH next cycle with ch_sel=0; mux_select=00000.
REQ-019 SHOW_FISH: mux_select=00001 for exactly DWELL_CYCLES cycles, then go to SAMPLE.
REQ-020 SAMPLE: sample_req=1 and mux_select=00000; on the first cycle with sample_valid=1, capture sample_data and go to LOAD.
REQ-021 SAMPLE timeout: after TIMEOUT_CYCLES cycles without valid, go to ERROR; valid in the same cycle as the timeout wins.
REQ-022 LOAD: lasts 1 cycle; ld_en[ch_sel]=1, ld_data=captured value, range check performed, then go to SHOW_CH.
REQ-023 Range check: value < LO[ch] or value > HI[ch] sets alarm_ch[ch]; limits are inclusive, unsigned 8-bit compare.
REQ-024 SHOW_CH: mux_select = channel mode (00010, 00100, 01000, 10000 for ch 0..3) for DWELL_CYCLES cycles.
REQ-025 SHOW_CH exit: if ch_sel<3, increment ch_sel and go to SAMPLE; if ch_sel=3, go to IDLE with ch_sel=0 (no wrap to 4).
REQ-026 ERROR: mux_select=11111, alarm=1, sample_req=0, ld_en=0; start ignored; alarm_clr=1 goes to IDLE and clears alarm_ch.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 alarm_clr outside ERROR clears alarm_ch; a set in the same cycle wins over the clear.
REQ-029 A zero-wait scan SHALL hold busy for exactly DWELL_CYCLES + 4*(2+DWELL_CYCLES) cycles (28 at defaults).
REQ-030 Dwell and timeout counters SHALL be 8-bit, reload on state entry and never wrap.

Reset
REQ-031 Reset, including mid-scan, SHALL immediately force IDLE with ch_sel=0, ld_en=0, ld_data=0, sample_req=0, mux_select=00000, busy=0, alarm_ch=0000, alarm=0, and both counters at 0.

Configuration
REQ-032 Macro TANK_ALARM_STICKY_EN defined: alarm_ch bits are sticky across scans until alarm_clr or reset.
REQ-033 Macro TANK_ALARM_STICKY_EN undefined: each LOAD overwrites alarm_ch[ch_sel] with the current check result.

Structure
REQ-034 Package tank_pkg SHALL hold the FSM state enum, the mux_select mode constants (00000, 00001, 00010, 00100, 01000, 10000, 11111), and the LO/HI limit arrays.
REQ-035 Limit values: clean [0x08,0xFF], temp [0x14,0x1E], food [0x10,0xFF], salt [0x20,0x60].
REQ-036 One sub-module, tank_dwell_timer: loadable 8-bit down-counter with a done flag, instanced once and shared by the dwell and timeout functions.

Verification
REQ-037 Reset then start, valid immediate, samples 0x0E,0x1C,0x38,0x70 -> mux sequence 00001,00010,00100,01000,10000 each 4 cycles, ld_en 0001,0010,0100,1000, alarm_ch=1000, busy 28 cycles.
REQ-038 Channel 1 valid never asserted -> ERROR after 8 SAMPLE cycles, mux_select=11111, alarm=1; alarm_clr -> IDLE, alarm_ch=0000.
REQ-039 Valid on the 8th SAMPLE cycle -> LOAD taken, no ERROR.
REQ-040 Two scans, salt 0x70 then 0x40 -> alarm_ch[3]=1 with TANK_ALARM_STICKY_EN, 0 without.
REQ-041 Reset asserted during SHOW_CH of channel 2 -> all outputs reach reset values without waiting for CLK; next start restarts at SHOW_FISH.
REQ-042 Boundary samples temp 0x14 and 0x1E -> no alarm; 0x13 and 0x1F -> alarm_ch[1]=1.
